// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Requester-side front end for an iterative ALU. Accepts one operation per
//   valid/ready handshake, drives registered operands/opcode to the ALU, pulses
//   the MOD unit restart, waits the op latency, then returns the ALU result on a
//   valid/ready response channel.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   req_valid/req_ready request handshake (ready only while IDLE)
//   req_a, req_b, req_op operands and opcode
//                       (000 AND,001 OR,010 XOR,011 NOR,100 SLT,101 ADD,110 SUB,111 MOD)
//   alu_a, alu_b, alu_op registered operands/opcode to the ALU
//   alu_rst             active-low restart to the ALU MOD unit
//   alu_s               ALU result
//   rsp_valid/rsp_ready response handshake
//   rsp_data, rsp_err   captured result; err = MOD with B==0
//   busy                high in any state other than IDLE
//
// Configuration
//   ALU_SEQ_CHECK_EN    adds chk_mismatch output and a golden result model; a
//                       capture that disagrees with the model sets chk_mismatch
//                       sticky until reset (MOD by zero never flags).
module alu_op_sequencer #(
  parameter int WIDTH     = 32,
  parameter int COMB_WAIT = 1,
  parameter int MOD_WAIT  = 64,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [2:0]       req_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_rst,
  input  logic [WIDTH-1:0] alu_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
`ifdef ALU_SEQ_CHECK_EN
  output logic             chk_mismatch,
`endif
  output logic             busy
);

  localparam logic [2:0]       OP_MOD = 3'b111;
  localparam logic [CNT_W-1:0] COMB_N = CNT_W'(COMB_WAIT);
  localparam logic [CNT_W-1:0] MOD_N  = CNT_W'(MOD_WAIT);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             err;

`ifdef ALU_SEQ_CHECK_EN
  function automatic logic [WIDTH-1:0] golden(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0]       op);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (op)
      3'b000:  golden = a & b;
      3'b001:  golden = a | b;
      3'b010:  golden = a ^ b;
      3'b011:  golden = ~(a | b);
      3'b100:  golden = {{(WIDTH-1){1'b0}}, (sa < sb)};
      3'b101:  golden = a + b;
      3'b110:  golden = a - b;
      default: golden = (b == '0) ? '0 : (a % b);
    endcase
  endfunction
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 3'b000;
      alu_rst   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
`ifdef ALU_SEQ_CHECK_EN
      chk_mismatch <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          alu_rst <= 1'b1;
          if (req_valid) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_op  <= req_op;
            err     <= (req_op == OP_MOD) && (req_b == '0);
            // Restart pulse is presented during LOAD only for MOD.
            alu_rst <= (req_op != OP_MOD);
            state   <= LOAD;
          end
        end
        LOAD: begin
          alu_rst <= 1'b1;
          // WAIT spends one cycle at count zero before capturing, so the
          // result is sampled N cycles after restart release plus a settle cycle.
          cnt     <= (alu_op == OP_MOD) ? MOD_N : COMB_N;
          state   <= WAIT;
        end
        WAIT: begin
          alu_rst <= 1'b1;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data  <= alu_s;
            rsp_err   <= err;
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef ALU_SEQ_CHECK_EN
            if (!err && (alu_s != golden(alu_a, alu_b, alu_op)))
              chk_mismatch <= 1'b1;
`endif
          end
        end
        RESP: begin
          alu_rst <= 1'b1;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
